// File: rtl/hw_rng_gen.sv
// Seedable xorshift32 random source: on a start pulse it fills an NBITS-bit result,
// one 32-bit word per cycle, and then pulses done with the new result already valid.
module hw_rng_gen #(
  parameter int          NBITS    = 1024,
  parameter logic [31:0] SEED_DEF = 32'h2545F491
) (
  input  logic             hclk,
  input  logic             hreset,
  input  logic             enable_p_rng,
  input  logic             seed_wr,
  input  logic [31:0]      seed,
  output logic             busy,
  output logic             done_irq_p_rng,
  output logic [NBITS-1:0] rng_y,
  output logic             rng_ovr
);

  localparam int            K    = NBITS / 32;
  localparam int            CW   = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t           r_state, w_next_state;
  logic [31:0]      r_lfsr;
  logic [CW-1:0]    r_cnt;
  logic [NBITS-1:0] r_shadow;
  logic [NBITS-1:0] r_rng_y;
  logic             r_done;
  logic             r_ovr;

  logic [31:0]      w_word;
  logic [31:0]      w_seed_eff;
  logic [NBITS-1:0] w_shift;
  logic             w_start, w_last, w_overrun, w_seed_ld;

  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  assign w_word     = xorshift32(r_lfsr);
  // Shifting in at the bottom leaves the first generated word at the top after K steps.
  assign w_shift    = {r_shadow[NBITS-33:0], w_word};
  assign w_seed_eff = (seed == 32'd0) ? SEED_DEF : seed;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_last       = 1'b0;
    w_overrun    = 1'b0;
    w_seed_ld    = 1'b0;
    case (r_state)
      IDLE: begin
        w_seed_ld = seed_wr;
        if (enable_p_rng) begin
          w_start      = 1'b1;
          w_next_state = FILL;
        end
      end
      FILL: begin
        w_overrun = enable_p_rng;
        if (r_cnt == LAST) begin
          w_last       = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_lfsr   <= SEED_DEF;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_rng_y  <= '0;
      r_done   <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_seed_ld) begin
        r_lfsr <= w_seed_eff;
        r_ovr  <= 1'b0;
      end
      if (w_start) r_cnt <= '0;
      if (r_state == FILL) begin
        r_lfsr   <= w_word;
        r_shadow <= w_shift;
        r_cnt    <= r_cnt + 1'b1;
      end
      if (w_last) begin
        r_rng_y <= w_shift;
        r_done  <= 1'b1;
      end
      if (w_overrun) r_ovr <= 1'b1;
    end
  end

  assign busy           = (r_state == FILL);
  assign done_irq_p_rng = r_done;
  assign rng_y          = r_rng_y;
  assign rng_ovr        = r_ovr;

endmodule

// File: tb/tb_hw_rng_gen.sv
// Bench for hw_rng_gen: a per-fill reference model checked every cycle, plus directed scenarios.
module tb_hw_rng_gen;

  localparam int          NBITS = 1024;
  localparam int          K     = NBITS / 32;
  localparam logic [31:0] DEF   = 32'h2545F491;

  logic             hclk = 1'b0;
  logic             hreset;
  logic             enable_p_rng;
  logic             seed_wr;
  logic [31:0]      seed;
  logic             busy;
  logic             done_irq_p_rng;
  logic [NBITS-1:0] rng_y;
  logic             rng_ovr;

  hw_rng_gen #(.NBITS(NBITS), .SEED_DEF(DEF)) dut (
    .hclk(hclk), .hreset(hreset), .enable_p_rng(enable_p_rng), .seed_wr(seed_wr),
    .seed(seed), .busy(busy), .done_irq_p_rng(done_irq_p_rng), .rng_y(rng_y),
    .rng_ovr(rng_ovr)
  );

  always #5 hclk = ~hclk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;

  always @(posedge hclk) cyc <= cyc + 1;

  function automatic logic [31:0] f(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // Whole result of one fill: word i (generated i-th) lands at word slot K-1-i.
  function automatic logic [NBITS-1:0] fill_words(input logic [31:0] s);
    logic [NBITS-1:0] r;
    logic [31:0]      x;
    r = '0;
    x = s;
    for (int i = 0; i < K; i++) begin
      x = f(x);
      r[(K-1-i)*32 +: 32] = x;
    end
    return r;
  endfunction

  function automatic logic [31:0] step_n(input logic [31:0] s, input int n);
    logic [31:0] x;
    x = s;
    for (int i = 0; i < n; i++) x = f(x);
    return x;
  endfunction

  function automatic logic [31:0] eff_seed(input logic [31:0] s);
    return (s == 32'd0) ? DEF : s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkw(input string name, input logic [NBITS-1:0] act, input logic [NBITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      for (int w = K - 1; w >= 0; w--) begin
        if (act[w*32 +: 32] !== exp[w*32 +: 32]) begin
          $display("FAIL %s: word %0d got %h expected %h (cycle %0d)", name, w,
                   act[w*32 +: 32], exp[w*32 +: 32], cyc);
          break;
        end
      end
    end
  endtask

  // Reference model: a fill is an accepted start followed by K busy cycles and a done cycle.
  logic [31:0]      m_lfsr;
  int               m_left;
  logic [NBITS-1:0] m_pending, m_rng;
  logic             m_done, m_ovr;

  always @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      m_lfsr    <= DEF;
      m_left    <= 0;
      m_pending <= '0;
      m_rng     <= '0;
      m_done    <= 1'b0;
      m_ovr     <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (seed_wr) begin
          m_lfsr <= eff_seed(seed);
          m_ovr  <= 1'b0;
        end
        if (enable_p_rng) begin
          m_pending <= fill_words(seed_wr ? eff_seed(seed) : m_lfsr);
          m_lfsr    <= step_n(seed_wr ? eff_seed(seed) : m_lfsr, K);
          m_left    <= K;
        end
      end else begin
        if (m_left == 1) begin
          m_rng  <= m_pending;
          m_done <= 1'b1;
        end
        if (enable_p_rng) m_ovr <= 1'b1;
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge hclk) begin
    if (!hreset) begin
      chk("busy", 32'(busy), 32'(m_left != 0));
      chk("done", 32'(done_irq_p_rng), 32'(m_done));
      chk("ovr", 32'(rng_ovr), 32'(m_ovr));
      chkw("rng_y", rng_y, m_rng);
    end
  end

  task automatic start(input logic sw, input logic [31:0] sv);
    enable_p_rng = 1'b1;
    seed_wr      = sw;
    seed         = sv;
    t0           = cyc;
    @(negedge hclk);
    enable_p_rng = 1'b0;
    seed_wr      = 1'b0;
  endtask

  task automatic load(input logic [31:0] sv);
    seed_wr = 1'b1;
    seed    = sv;
    @(negedge hclk);
    seed_wr = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int b;
    b = 0;
    while (!done_irq_p_rng && b < 100) begin
      @(negedge hclk);
      b++;
    end
    chk(name, done_irq_p_rng ? 32'(cyc - t0) : 32'hFFFF_FFFF, 32'd33);
  endtask

  logic [NBITS-1:0] r0, ra, rp;
  int               dcount;

  initial begin
    hreset = 1'b1; enable_p_rng = 1'b0; seed_wr = 1'b0; seed = '0;
    repeat (3) @(negedge hclk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done_irq_p_rng), 32'd0);
    chk("rst_ovr", 32'(rng_ovr), 32'd0);
    chkw("rst_rng_y", rng_y, '0);
    hreset = 1'b0;
    @(negedge hclk);

    // Fill straight from reset, then with seed 0 and with the default seed loaded.
    start(1'b0, 32'd0);
    wait_done("lat_from_reset");
    r0 = rng_y;
    @(negedge hclk);
    load(32'd0);
    start(1'b0, 32'd0);
    wait_done("lat_seed0");
    chkw("seed0_eq_reset", rng_y, r0);
    @(negedge hclk);
    load(DEF);
    start(1'b0, 32'd0);
    wait_done("lat_seeddef");
    chkw("seeddef_eq_reset", rng_y, r0);

    // Seed 1 loaded separately, then started.
    @(negedge hclk);
    load(32'd1);
    start(1'b0, 32'd0);
    wait_done("lat_seed1");
    ra = rng_y;
    chk("seed1_w0", ra[1023:992], 32'h00042021);
    chk("seed1_w1", ra[991:960], 32'h04080601);

    // Seed load and start in the same cycle, with a seed write mid-fill that must be ignored.
    @(negedge hclk);
    start(1'b1, 32'd1);
    repeat (4) @(negedge hclk);
    load(32'h0000_1234);
    wait_done("lat_same_cycle");
    chk("same_cycle_w0", rng_y[1023:992], 32'h00042021);
    chkw("same_cycle_eq_seed1", rng_y, ra);

    // Start while busy: ignored, flags overrun; an idle seed write clears it.
    @(negedge hclk);
    start(1'b0, 32'd0);
    repeat (4) @(negedge hclk);
    enable_p_rng = 1'b1;
    @(negedge hclk);
    enable_p_rng = 1'b0;
    wait_done("lat_overrun");
    chk("ovr_set", 32'(rng_ovr), 32'd1);
    @(negedge hclk);
    load(32'd7);
    chk("ovr_clear", 32'(rng_ovr), 32'd0);

    // Back-to-back: restart in the done cycle.
    start(1'b0, 32'd0);
    wait_done("lat_b2b_first");
    rp = rng_y;
    start(1'b0, 32'd0);
    repeat (19) @(negedge hclk);
    chkw("b2b_hold", rng_y, rp);
    wait_done("lat_b2b_second");
    chk("b2b_continue", rng_y[1023:992], f(rp[31:0]));

    // Reset in cycle 10 of a fill.
    @(negedge hclk);
    start(1'b0, 32'd0);
    repeat (9) @(negedge hclk);
    hreset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done_irq_p_rng), 32'd0);
    chk("midrst_ovr", 32'(rng_ovr), 32'd0);
    chkw("midrst_rng_y", rng_y, '0);
    @(negedge hclk);
    hreset = 1'b0;
    dcount = 0;
    repeat (40) begin
      @(negedge hclk);
      if (done_irq_p_rng) dcount++;
    end
    chk("midrst_no_done", 32'(dcount), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
